// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between instruction memory and the IF/ID register.
//
// The queue issues sequential word fetches, buffers up to DEPTH returned instructions with
// their PC tags, and presents them in order under a valid/ready handshake. A redirect
// flushes the buffer, marks the in-flight responses as stale, and restarts fetching at the
// new target.
//
// Parameters:
//   DEPTH     - queue entries (power of two, >= 2)
//   RESET_PC  - first fetch address after reset
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc - flush and refetch from redirect_pc (low two bits ignored)
//   imem_req, imem_addr   - fetch request and word address
//   imem_ready            - memory accepts the request this cycle
//   imem_rvalid/rdata     - in-order instruction responses
//   out_valid/instr/pc    - head of queue (instr and pc read 0 when out_valid is 0)
//   out_ready             - fetch stage consumes the head
//
// Build option: define IFQ_BYPASS_EN to forward a kept response straight to the outputs in
// the cycle it arrives when the queue is empty.

module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] infl_q, infl_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q    [DEPTH];

    logic [CntW:0] credit_sum;
    logic          queue_valid;
    logic          accept;
    logic          resp_live;
    logic          keep;
    logic          push;
    logic          pop;
    logic          bypass_take;
    logic [31:0]   redirect_target;

    // Control decode. Requests are credit-limited so every kept response has a free slot.
    always_comb begin
        credit_sum      = {1'b0, count_q} + {1'b0, infl_q};
        queue_valid     = (count_q != '0);
        imem_req        = !reset && !redirect && (credit_sum < CreditMax);
        imem_addr       = reset ? RESET_PC : fetch_pc_q;
        accept          = imem_req && imem_ready;
        // A response with nothing outstanding is spurious and ignored.
        resp_live       = imem_rvalid && (infl_q != '0);
        keep            = resp_live && (drop_cnt_q == '0) && !redirect;
        pop             = queue_valid && out_ready && !redirect;
`ifdef IFQ_BYPASS_EN
        bypass_take     = keep && !queue_valid && out_ready;
`else
        bypass_take     = 1'b0;
`endif
        push            = keep && !bypass_take;
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
    end

    // Head presentation.
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        if (!reset) begin
            if (queue_valid) begin
                out_valid = 1'b1;
                out_instr = instr_mem_q[rd_ptr_q];
                out_pc    = pc_mem_q[rd_ptr_q];
            end
`ifdef IFQ_BYPASS_EN
            else if (keep) begin
                out_valid = 1'b1;
                out_instr = imem_rdata;
                out_pc    = resp_pc_q;
            end
`endif
        end
    end

    // Next-state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        infl_d     = infl_q + CntW'(accept) - CntW'(resp_live);

        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            drop_cnt_d = infl_q - CntW'(resp_live);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (resp_live && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            infl_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            infl_q     <= infl_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    rvalid_has_credit: assert property (
        @(posedge clk) disable iff (reset) imem_rvalid |-> (infl_q != '0)
    );
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed testbench for ifetch_queue (default build, DEPTH=4).
// A behavioural instruction memory returns addr ^ KEY after a programmable latency.

module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    int          cyc;
    int          mem_lat;
    int          errors;
    int          checks;
    logic        s_req;
    logic        s_ovalid;
    logic [31:0] s_addr;
    logic [31:0] s_opc;
    logic [31:0] s_oinstr;

    // One clock cycle: drive the memory response, sample outputs at the falling edge,
    // record any accepted request, then advance past the rising edge.
    task automatic cycle();
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ KEY;
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        @(negedge clk);
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_ovalid = out_valid;
        s_opc    = out_pc;
        s_oinstr = out_instr;
        if (imem_req && imem_ready) begin
            mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds reset for at least two cycles and until the memory has no responses left.
    task automatic test_reset();
        int n = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        imem_ready  = 1'b1;
        while ((n < 2 || mem_q.size() != 0) && n < 20) begin
            cycle();
            checks++;
            if (s_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", s_req);
            if (s_req !== 1'b0) errors++;
            checks++;
            if (s_addr !== RESET_PC) begin
                errors++;
                $display("FAIL reset_addr: got %h want %h", s_addr, RESET_PC);
            end
            checks++;
            if (s_ovalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid: got %0b want 0", s_ovalid);
            end
            checks++;
            if (s_opc !== 32'h0 || s_oinstr !== 32'h0) begin
                errors++;
                $display("FAIL reset_out_zero: got pc=%h instr=%h want 0/0", s_opc, s_oinstr);
            end
            n++;
        end
        checks++;
        if (mem_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d pending want 0", mem_q.size());
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        mem_lat = 1;
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_req c%0d: got %0b/%h want 1/%h", k, s_req, s_addr, 4 * k);
            end
            checks++;
            if (s_ovalid !== (k >= 2)) begin
                errors++;
                $display("FAIL stream_valid c%0d: got %0b want %0b", k, s_ovalid, (k >= 2));
            end
            if (k >= 2) begin
                exp_pc = 32'(4 * (k - 2));
                checks++;
                if (s_opc !== exp_pc || s_oinstr !== (exp_pc ^ KEY)) begin
                    errors++;
                    $display("FAIL stream_head c%0d: got %h/%h want %h/%h", k, s_opc, s_oinstr,
                             exp_pc, exp_pc ^ KEY);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          nreq = 0;
        logic [31:0] exp_pc;
        mem_lat = 1;
        test_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_req) nreq++;
            if (k >= 4) begin
                checks++;
                if (s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_req_stall c%0d: got %0b want 0", k, s_req);
                end
            end
            if (k >= 2) begin
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== 32'h0) begin
                    errors++;
                    $display("FAIL bp_head_hold c%0d: got %0b/%h want 1/0", k, s_ovalid, s_opc);
                end
            end
        end
        checks++;
        if (nreq != DEPTH) begin
            errors++;
            $display("FAIL bp_req_count: got %0d want %0d", nreq, DEPTH);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            exp_pc = 32'(4 * i);
            checks++;
            if (s_ovalid !== 1'b1 || s_opc !== exp_pc || s_oinstr !== (exp_pc ^ KEY)) begin
                errors++;
                $display("FAIL bp_drain %0d: got %0b/%h/%h want 1/%h/%h", i, s_ovalid, s_opc,
                         s_oinstr, exp_pc, exp_pc ^ KEY);
            end
            if (i == 0) begin
                checks++;
                if (s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full_req: got %0b want 0", s_req);
                end
            end
            if (i == 1) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h10) begin
                    errors++;
                    $display("FAIL bp_resume: got %0b/%h want 1/00000010", s_req, s_addr);
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc;
        mem_lat = 3;
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            redirect    = (k == 3);
            redirect_pc = 32'h400;
            cycle();
            if (k == 3) begin
                checks++;
                if (s_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rdi_req_suppress: got %0b want 0", s_req);
                end
            end
            if (k == 4) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h400) begin
                    errors++;
                    $display("FAIL rdi_refetch: got %0b/%h want 1/00000400", s_req, s_addr);
                end
            end
            if (k < 8) begin
                checks++;
                if (s_ovalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rdi_stale c%0d: got valid pc=%h want no output", k, s_opc);
                end
            end else begin
                exp_pc = 32'h400 + 32'(4 * (k - 8));
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== exp_pc || s_oinstr !== (exp_pc ^ KEY)) begin
                    errors++;
                    $display("FAIL rdi_new c%0d: got %0b/%h/%h want 1/%h/%h", k, s_ovalid, s_opc,
                             s_oinstr, exp_pc, exp_pc ^ KEY);
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_redirect_collision();
        mem_lat = 1;
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            redirect    = (k == 3);
            redirect_pc = 32'h200;
            cycle();
            if (k == 3) begin
                checks++;
                if (s_req !== 1'b0 || imem_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL col_req: got req=%0b rvalid=%0b want 0/1", s_req, imem_rvalid);
                end
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== 32'h4) begin
                    errors++;
                    $display("FAIL col_head: got %0b/%h want 1/00000004", s_ovalid, s_opc);
                end
            end
            if (k == 4) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== 32'h200) begin
                    errors++;
                    $display("FAIL col_refetch: got %0b/%h want 1/00000200", s_req, s_addr);
                end
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (s_ovalid !== 1'b0) begin
                    errors++;
                    $display("FAIL col_flushed c%0d: got valid pc=%h want empty", k, s_opc);
                end
            end
            if (k == 6) begin
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== 32'h200 || s_oinstr !== (32'h200 ^ KEY)) begin
                    errors++;
                    $display("FAIL col_first: got %0b/%h/%h want 1/00000200/%h", s_ovalid, s_opc,
                             s_oinstr, 32'h200 ^ KEY);
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_addr [6];
        logic [31:0] exp_pc   [6];
        exp_addr = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_pc   = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        mem_lat = 1;
        test_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            redirect    = (k == 0);
            redirect_pc = 32'hFFFF_FFFB;  // low bits must be ignored
            cycle();
            if (k >= 1) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== exp_addr[k]) begin
                    errors++;
                    $display("FAIL wrap_addr c%0d: got %0b/%h want 1/%h", k, s_req, s_addr,
                             exp_addr[k]);
                end
            end
            if (k >= 3) begin
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== exp_pc[k] || s_oinstr !== (exp_pc[k] ^ KEY))
                begin
                    errors++;
                    $display("FAIL wrap_pc c%0d: got %0b/%h/%h want 1/%h/%h", k, s_ovalid, s_opc,
                             s_oinstr, exp_pc[k], exp_pc[k] ^ KEY);
                end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_midstream();
        mem_lat = 3;
        test_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
        end
        checks++;
        if (s_ovalid !== 1'b1 || s_opc !== 32'h0 || mem_q.size() != 2) begin
            errors++;
            $display("FAIL mid_setup: got %0b/%h pending=%0d want 1/0/2", s_ovalid, s_opc,
                     mem_q.size());
        end
        // Two stale responses arrive while reset is held.
        test_reset();
        mem_lat   = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (k == 0) begin
                checks++;
                if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
                    errors++;
                    $display("FAIL mid_restart: got %0b/%h want 1/%h", s_req, s_addr, RESET_PC);
                end
            end
            if (k < 2) begin
                checks++;
                if (s_ovalid !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_empty c%0d: got valid pc=%h want empty", k, s_opc);
                end
            end else begin
                checks++;
                if (s_ovalid !== 1'b1 || s_opc !== RESET_PC || s_oinstr !== (RESET_PC ^ KEY)) begin
                    errors++;
                    $display("FAIL mid_first: got %0b/%h/%h want 1/%h/%h", s_ovalid, s_opc,
                             s_oinstr, RESET_PC, RESET_PC ^ KEY);
                end
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        mem_lat     = 1;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_pc_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
